// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage drives the master side; the unit implements the slave side.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            start;
    logic            flush;
    logic [2:0]      Operation;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;

    modport master (
        output start, flush, Operation, SrcA, SrcB,
        input  busy, done, Result
    );

    modport slave (
        input  start, flush, Operation, SrcA, SrcB,
        output busy, done, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring divider
// sharing one 2*XLEN accumulator, with sign fix-up in a final cycle.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpRem    = 3'b110;

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   opa, opb;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     add_sum, trial;
    logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
    logic [XLEN-1:0]   div_sel, div_fix, fix_result;

    always_comb begin
        a_signed = (bus.Operation == OpMulh) || (bus.Operation == OpMulhsu) ||
                   (bus.Operation == OpDiv) || (bus.Operation == OpRem);
        b_signed = (bus.Operation == OpMulh) || (bus.Operation == OpDiv) ||
                   (bus.Operation == OpRem);
        sa       = a_signed & bus.SrcA[XLEN-1];
        sb       = b_signed & bus.SrcB[XLEN-1];
        opa      = sa ? -bus.SrcA : bus.SrcA;
        opb      = sb ? -bus.SrcB : bus.SrcB;
        div_zero = bus.Operation[2] && (bus.SrcB == '0);
        div_ovf  = ((bus.Operation == OpDiv) || (bus.Operation == OpRem)) &&
                   (bus.SrcA == MinNeg) && (bus.SrcB == '1);
    end

    // Multiply: add multiplicand into the upper half, shift right, keep the carry.
    // Divide: remainder:quotient shifted left; upper XLEN+1 bits form the trial remainder.
    always_comb begin
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {add_sum, acc_q[XLEN-1:1]};
        trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        div_next = {trial[XLEN] ? acc_q[2*XLEN-2:XLEN-1] : trial[XLEN-1:0],
                    acc_q[XLEN-2:0], ~trial[XLEN]};
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        div_sel  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_fix  = neg_q ? -div_sel : div_sel;
        if (op_q[2]) begin
            fix_result = div_fix;
        end else if (op_q == OpMul) begin
            fix_result = prod_fix[XLEN-1:0];
        end else begin
            fix_result = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (div_zero) begin
                            result_d = bus.Operation[1] ? bus.SrcA : '1;
                            done_d   = 1'b1;
                        end else if (div_ovf) begin
                            result_d = bus.Operation[1] ? '0 : MinNeg;
                            done_d   = 1'b1;
                        end else begin
                            op_d    = bus.Operation;
                            // Remainder follows the dividend; product/quotient follow sa^sb.
                            neg_d   = ((bus.Operation == OpMulhsu) || (bus.Operation == OpRem)) ?
                                      sa : (sa ^ sb);
                            opnd_d  = bus.Operation[2] ? opb : opa;
                            acc_d   = {{XLEN{1'b0}}, bus.Operation[2] ? opa : opb};
                            cnt_d   = '0;
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(XLEN - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    result_d = fix_result;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = done_q;
    assign bus.Result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic, special cases, handshake,
// flush and asynchronous reset.
module tb_muldiv_unit;
    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issues one op and waits for done; lat counts edges after the start edge (-1 on timeout).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.Operation = op;
        bus.SrcA = a;
        bus.SrcB = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.SrcA = 32'h0;
        bus.SrcB = 32'h0;
        lat = -1;
        bcnt = 0;
        res = 'x;
        for (int n = 0; n < 100; n++) begin
            if (bus.done) begin
                lat = n;
                res = bus.Result;
                break;
            end
            if (bus.busy) bcnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", bus.done);
        end
        checks++;
        if (bus.Result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h want 00000000", bus.Result);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multiply();
        logic [31:0] res;
        int lat, bcnt;
        run_op(MUL, 32'd7, 32'hFFFF_FFFD, res, lat, bcnt);
        checks++;
        if (res !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_result: got %h want ffffffeb", res);
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL mul_latency: got %0d want 33", lat);
        end
        checks++;
        if (bcnt !== 33) begin
            errors++;
            $display("FAIL mul_busy_cycles: got %0d want 33", bcnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mul_done_pulse: got %b want 0", bus.done);
        end
        run_op(MULH, 32'h8000_0000, 32'h8000_0000, res, lat, bcnt);
        checks++;
        if (res !== 32'h4000_0000) begin
            errors++;
            $display("FAIL mulh_result: got %h want 40000000", res);
        end
        run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bcnt);
        checks++;
        if (res !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mulhu_result: got %h want fffffffe", res);
        end
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bcnt);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mulhsu_result: got %h want ffffffff", res);
        end
    endtask

    task automatic test_divide();
        logic [31:0] res;
        int lat, bcnt;
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_result: got %h want fffffffd", res);
        end
        run_op(REM, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rem_result: got %h want ffffffff", res);
        end
        run_op(DIVU, 32'd100, 32'd7, res, lat, bcnt);
        checks++;
        if (res !== 32'd14) begin
            errors++;
            $display("FAIL divu_result: got %h want 0000000e", res);
        end
        run_op(REMU, 32'd100, 32'd7, res, lat, bcnt);
        checks++;
        if (res !== 32'd2) begin
            errors++;
            $display("FAIL remu_result: got %h want 00000002", res);
        end
    endtask

    task automatic test_special();
        logic [31:0] res;
        int lat, bcnt;
        run_op(DIVU, 32'd5, 32'd0, res, lat, bcnt);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divu_by_zero: got %h want ffffffff", res);
        end
        checks++;
        if (lat !== 0 || bcnt !== 0) begin
            errors++;
            $display("FAIL divu_by_zero_timing: lat %0d busy %0d want 0 0", lat, bcnt);
        end
        run_op(REMU, 32'd5, 32'd0, res, lat, bcnt);
        checks++;
        if (res !== 32'd5) begin
            errors++;
            $display("FAIL remu_by_zero: got %h want 00000005", res);
        end
        checks++;
        if (lat !== 0 || bcnt !== 0) begin
            errors++;
            $display("FAIL remu_by_zero_timing: lat %0d busy %0d want 0 0", lat, bcnt);
        end
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcnt);
        checks++;
        if (res !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_overflow: got %h want 80000000", res);
        end
        checks++;
        if (lat !== 0 || bcnt !== 0) begin
            errors++;
            $display("FAIL div_overflow_timing: lat %0d busy %0d want 0 0", lat, bcnt);
        end
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcnt);
        checks++;
        if (res !== 32'h0) begin
            errors++;
            $display("FAIL rem_overflow: got %h want 00000000", res);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int lat1, lat2;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Operation = MUL;
        bus.SrcA = 32'd3;
        bus.SrcB = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat1 = -1;
        r1 = 'x;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                lat1 = i;
                r1 = bus.Result;
                break;
            end
            if (i == 10) begin
                bus.start = 1'b1;
                bus.Operation = MUL;
                bus.SrcA = 32'd9;
                bus.SrcB = 32'd9;
            end else if (i == 11) begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (r1 !== 32'd12 || lat1 !== 33) begin
            errors++;
            $display("FAIL start_while_busy: result %h lat %0d want 0000000c 33", r1, lat1);
        end
        // Still in the done cycle: issue the next op immediately.
        bus.start = 1'b1;
        bus.Operation = DIVU;
        bus.SrcA = 32'd9;
        bus.SrcB = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_cycle: busy %b done %b want 1 0", bus.busy, bus.done);
        end
        lat2 = -1;
        r2 = 'x;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                lat2 = i;
                r2 = bus.Result;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (r2 !== 32'd3 || lat2 !== 33) begin
            errors++;
            $display("FAIL back_to_back_divu: result %h lat %0d want 00000003 33", r2, lat2);
        end
    endtask

    task automatic test_flush();
        int dcount;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Operation = MUL;
        bus.SrcA = 32'd5;
        bus.SrcB = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy %b done %b want 0 0", bus.busy, bus.done);
        end
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dcount++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (dcount !== 0) begin
            errors++;
            $display("FAIL flush_no_done: got %0d done pulses want 0", dcount);
        end
        checks++;
        if (bus.Result !== 32'd3) begin
            errors++;
            $display("FAIL flush_result_kept: got %h want 00000003", bus.Result);
        end
        // A start coinciding with flush is dropped, even a single-cycle special case.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.Operation = DIVU;
        bus.SrcA = 32'd5;
        bus.SrcB = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Result !== 32'd3) begin
            errors++;
            $display("FAIL flush_with_start: done %b busy %b result %h want 0 0 00000003",
                     bus.done, bus.busy, bus.Result);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res;
        int lat, bcnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Operation = DIV;
        bus.SrcA = 32'h1234_5678;
        bus.SrcB = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Result !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: busy %b done %b result %h want 0 0 00000000",
                     bus.busy, bus.done, bus.Result);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt);
        checks++;
        if (res !== 32'hFFFF_FFFD || lat !== 33) begin
            errors++;
            $display("FAIL div_after_reset: result %h lat %0d want fffffffd 33", res, lat);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.Operation = 3'b000;
        bus.SrcA = 32'h0;
        bus.SrcB = 32'h0;
        test_reset();
        test_multiply();
        test_divide();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
